// File: rtl/data_mem_pkg.sv
// Shared constants, encodings and memory reset image for the data-memory DMA
// engine and anything that models the 32-byte data memory it drives.
package data_mem_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LEN_W     = ADDR_W + 1;
    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        MODE_COPY = 2'b00,
        MODE_FILL = 2'b01,
        MODE_SUM  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR,
        ST_FIN
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              rd;
        logic              wr;
    } mem_req_t;

    // Reset image: ascending ramp 0..15, then 0,-1,-2,...,-15 in the upper half.
    function automatic logic [DATA_W-1:0] mem_reset_value(input logic [ADDR_W-1:0] a);
        if (a < ADDR_W'(16)) begin
            return DATA_W'(a);
        end
        return DATA_W'(0) - DATA_W'(a - ADDR_W'(16));
    endfunction

endpackage

// File: rtl/data_mem_dma.sv
// Block-operation initiator (copy / fill / checksum) on the data-memory port.
// All port outputs come straight from registers loaded with next-state values.
module data_mem_dma
    import data_mem_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [1:0]        Mode,
    input  logic [ADDR_W-1:0] Src_Addr,
    input  logic [ADDR_W-1:0] Dst_Addr,
    input  logic [LEN_W-1:0]  Length,
    input  logic [DATA_W-1:0] Fill_Data,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Sum,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Write_Data,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] Read_Data
);

    state_e            r_state, w_state;
    mode_e             r_mode,  w_mode;
    logic [ADDR_W-1:0] r_src,   w_src;
    logic [ADDR_W-1:0] r_dst,   w_dst;
    logic [LEN_W-1:0]  r_cnt,   w_cnt;
    logic [DATA_W-1:0] r_fill,  w_fill;
    logic [DATA_W-1:0] r_acc,   w_acc;
    logic              r_busy,  w_busy;
    logic              r_done,  w_done;
    logic [DATA_W-1:0] r_sum,   w_sum;
    mem_req_t          r_req,   w_req;

    mode_e             w_mode_in;
    logic              w_last;
    logic [DATA_W-1:0] w_acc_add;
    logic [ADDR_W-1:0] w_src_inc;
    logic [ADDR_W-1:0] w_dst_inc;

    assign w_mode_in = mode_e'(Mode);
    assign w_last    = (r_cnt == LEN_W'(1));
    assign w_acc_add = r_acc + Read_Data;
    assign w_src_inc = r_src + ADDR_W'(1);
    assign w_dst_inc = r_dst + ADDR_W'(1);

    // Next state plus next value of every registered output.
    always_comb begin
        w_state   = r_state;
        w_mode    = r_mode;
        w_src     = r_src;
        w_dst     = r_dst;
        w_cnt     = r_cnt;
        w_fill    = r_fill;
        w_acc     = r_acc;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_sum     = r_sum;
        w_req     = r_req;
        w_req.rd  = 1'b0;
        w_req.wr  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_mode = w_mode_in;
                    w_src  = Src_Addr;
                    w_dst  = Dst_Addr;
                    w_cnt  = Length;
                    w_fill = Fill_Data;
                    w_acc  = '0;
                    if ((Length == '0) || (w_mode_in == MODE_RSVD)) begin
                        w_state = ST_FIN;
                        w_done  = 1'b1;
                        if (w_mode_in == MODE_SUM) begin
                            w_sum = '0;
                        end
                    end else if (w_mode_in == MODE_FILL) begin
                        w_state     = ST_WR;
                        w_busy      = 1'b1;
                        w_req.addr  = Dst_Addr;
                        w_req.wdata = Fill_Data;
                        w_req.wr    = 1'b1;
                    end else begin
                        w_state    = ST_RD_REQ;
                        w_busy     = 1'b1;
                        w_req.addr = Src_Addr;
                        w_req.rd   = 1'b1;
                    end
                end
            end

            ST_RD_REQ: begin
                w_state = ST_RD_WAIT;
                w_busy  = 1'b1;
            end

            // Read data is valid here; SUM retires the byte, COPY forwards it to the write.
            ST_RD_WAIT: begin
                w_src = w_src_inc;
                if (r_mode == MODE_SUM) begin
                    w_acc = w_acc_add;
                    w_cnt = r_cnt - LEN_W'(1);
                    if (w_last) begin
                        w_state = ST_FIN;
                        w_done  = 1'b1;
                        w_sum   = w_acc_add;
                    end else begin
                        w_state    = ST_RD_REQ;
                        w_busy     = 1'b1;
                        w_req.addr = w_src_inc;
                        w_req.rd   = 1'b1;
                    end
                end else begin
                    w_state     = ST_WR;
                    w_busy      = 1'b1;
                    w_req.addr  = r_dst;
                    w_req.wdata = Read_Data;
                    w_req.wr    = 1'b1;
                end
            end

            ST_WR: begin
                w_dst = w_dst_inc;
                w_cnt = r_cnt - LEN_W'(1);
                if (w_last) begin
                    w_state = ST_FIN;
                    w_done  = 1'b1;
                end else if (r_mode == MODE_FILL) begin
                    w_state     = ST_WR;
                    w_busy      = 1'b1;
                    w_req.addr  = w_dst_inc;
                    w_req.wdata = r_fill;
                    w_req.wr    = 1'b1;
                end else begin
                    w_state    = ST_RD_REQ;
                    w_busy     = 1'b1;
                    w_req.addr = r_src;
                    w_req.rd   = 1'b1;
                end
            end

            ST_FIN: begin
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_COPY;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_fill  <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_req   <= '0;
        end else begin
            r_state <= w_state;
            r_mode  <= w_mode;
            r_src   <= w_src;
            r_dst   <= w_dst;
            r_cnt   <= w_cnt;
            r_fill  <= w_fill;
            r_acc   <= w_acc;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_sum   <= w_sum;
            r_req   <= w_req;
        end
    end

    assign Busy       = r_busy;
    assign Done       = r_done;
    assign Sum        = r_sum;
    assign Address    = r_req.addr;
    assign Write_Data = r_req.wdata;
    assign MemRead    = r_req.rd;
    assign MemWrite   = r_req.wr;

endmodule
